// File: rtl/hevc_idct16_seq.sv
// hevc_idct16_seq: sequential 16-point 1-D inverse transform (one MAC per cycle).
//
// Loads 16 signed coefficients X[0..15]. For each output n = 0..15 it then runs
// 16 multiply-accumulate cycles against an external ROM, C[k][n]. The result is
// rounded, shifted and saturated, and presented under a valid/ready handshake.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input coefficient handshake, in_data = X[k] in order
//   rom_row/rom_col      ROM address (k, n) during MAC, 0 otherwise
//   rom_coeff            signed 8-bit ROM data, combinational for the same cycle
//   out_valid/out_ready  output handshake, out_data = y[n] in order
//   busy                 block partially loaded, computing or emitting
module hevc_idct16_seq #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int SHIFT = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic [3:0]       rom_row,
    output logic [3:0]       rom_col,
    input  logic [7:0]       rom_coeff,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    // 16 products of IN_W x 8 bits need 4 bits of growth on top of IN_W + 8.
    localparam int ACC_W = IN_W + 12;

    localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W + 1)'(1 << (SHIFT - 1));
    localparam logic signed [ACC_W:0] OUT_MAX  = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN  = (ACC_W + 1)'(-(1 << (OUT_W - 1)));

    typedef enum logic [1:0] {StLoad, StMac, StEmit} state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [3:0]              r_load_cnt;
    logic [3:0]              r_n;
    logic [3:0]              r_k;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [IN_W-1:0]  r_buf [16];

    logic signed [IN_W+7:0]  w_prod;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic signed [ACC_W:0]   w_rnd;
    logic signed [ACC_W:0]   w_scaled;
    logic [OUT_W-1:0]        w_sat;

    assign w_prod = r_buf[r_k] * $signed(rom_coeff);

    // k == 0 starts a fresh dot product for the current n.
    assign w_acc_nxt = ((r_k == 4'd0) ? '0 : r_acc)
                     + {{(ACC_W - IN_W - 8){w_prod[IN_W+7]}}, w_prod};

    // One guard bit so the rounding bias can never wrap the accumulator.
    assign w_rnd    = {r_acc[ACC_W-1], r_acc} + RND_BIAS;
    assign w_scaled = w_rnd >>> SHIFT;

    always_comb begin
        if (w_scaled > OUT_MAX) begin
            w_sat = OUT_MAX[OUT_W-1:0];
        end else if (w_scaled < OUT_MIN) begin
            w_sat = OUT_MIN[OUT_W-1:0];
        end else begin
            w_sat = w_scaled[OUT_W-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        rom_row     = 4'd0;
        rom_col     = 4'd0;
        case (r_state)
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid && (r_load_cnt == 4'd15)) begin
                    w_state_nxt = StMac;
                end
            end
            StMac: begin
                rom_row = r_k;
                rom_col = r_n;
                if (r_k == 4'd15) begin
                    w_state_nxt = StEmit;
                end
            end
            StEmit: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = (r_n == 4'd15) ? StLoad : StMac;
                end
            end
            default: w_state_nxt = StLoad;
        endcase
    end

    assign out_data = out_valid ? w_sat : '0;
    assign busy     = (r_state != StLoad) || (r_load_cnt != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StLoad;
            r_load_cnt <= 4'd0;
            r_n        <= 4'd0;
            r_k        <= 4'd0;
            r_acc      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                StLoad: begin
                    if (in_valid) begin
                        r_load_cnt <= r_load_cnt + 4'd1;
                        if (r_load_cnt == 4'd15) begin
                            r_n <= 4'd0;
                            r_k <= 4'd0;
                        end
                    end
                end
                StMac: begin
                    r_acc <= w_acc_nxt;
                    r_k   <= r_k + 4'd1;
                end
                StEmit: begin
                    if (out_ready) begin
                        r_k <= 4'd0;
                        r_n <= (r_n == 4'd15) ? 4'd0 : r_n + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sample storage carries no reset; stale contents are always overwritten by a full load.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == StLoad) && in_valid) begin
            r_buf[r_load_cnt] <= in_data;
        end
    end

endmodule

// File: tb/tb_hevc_idct16_seq.sv
// Directed testbench for hevc_idct16_seq. Provides the coefficient ROM
// (first 16 columns of rows 0..15 of the HEVC 32-point matrix) and checks
// reset, DC/basis/negative-rounding results, saturation, load pause,
// backpressure, throughput and reset recovery.
module tb_hevc_idct16_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  rom_row;
    logic [3:0]  rom_col;
    logic [7:0]  rom_coeff;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int total;
    int bad;
    int rom_tab [16][16];

    int exp_basis [16] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};
    int exp_neg   [16] = '{-90, -87, -80, -70, -57, -43, -25, -9, 9, 25, 43, 57, 70, 80, 87, 90};

    hevc_idct16_seq #(
        .IN_W (16),
        .OUT_W(16),
        .SHIFT(7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .rom_row  (rom_row),
        .rom_col  (rom_col),
        .rom_coeff(rom_coeff),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_coeff = rom_tab[rom_row][rom_col][7:0];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    // Stimulus helpers: start and end just after a falling edge.
    task automatic load_block(input int v[16]);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(v[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int first, input int last, output int y[16], output int lat[16]);
        for (int n = 0; n < 16; n++) begin
            y[n]   = 0;
            lat[n] = 0;
        end
        out_ready = 1'b1;
        for (int n = first; n < last; n++) begin
            while (out_valid !== 1'b1 && lat[n] < 100) begin
                @(negedge clk);
                lat[n]++;
            end
            y[n] = int'($signed(out_data));
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (rom_row !== 4'd0) begin bad++; $display("FAIL reset_rom_row: got %0d want 0", rom_row); end
        total++; if (rom_col !== 4'd0) begin bad++; $display("FAIL reset_rom_col: got %0d want 0", rom_col); end
        total++; if (out_data !== 16'd0) begin bad++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_dc();
        int v[16];
        int y[16];
        int lat[16];
        time t0;
        for (int i = 0; i < 16; i++) v[i] = 0;
        v[0] = 64;
        t0 = $time;
        load_block(v);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL dc_busy_mac: got %b want 1", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL dc_in_ready_mac: got %b want 0", in_ready); end
        collect(0, 16, y, lat);
        for (int n = 0; n < 16; n++) begin
            total++; if (y[n] != 32) begin bad++; $display("FAIL dc_y%0d: got %0d want 32", n, y[n]); end
            total++; if (lat[n] != 16) begin bad++; $display("FAIL dc_lat%0d: got %0d want 16", n, lat[n]); end
        end
        total++;
        if (($time - t0) != 64'd2880) begin
            bad++; $display("FAIL dc_block_time: got %0t want 2880", $time - t0);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dc_busy_done: got %b want 0", busy); end
    endtask

    task automatic test_basis_pause();
        int v[16];
        int y[16];
        int lat[16];
        for (int i = 0; i < 16; i++) v[i] = 0;
        v[1] = 128;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(v[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 16'h7777;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL pause_busy c%0d: got %b want 1", c, busy); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pause_in_ready c%0d: got %b want 1", c, in_ready); end
        end
        for (int i = 5; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(v[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        collect(0, 16, y, lat);
        for (int n = 0; n < 16; n++) begin
            total++;
            if (y[n] != exp_basis[n]) begin
                bad++; $display("FAIL basis_y%0d: got %0d want %0d", n, y[n], exp_basis[n]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int v[16];
        int y[16];
        int lat[16];
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 16'd1000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midload_busy: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midload_busy_rst: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) v[i] = 0;
        v[2] = -128;
        load_block(v);
        collect(0, 16, y, lat);
        for (int n = 0; n < 16; n++) begin
            total++;
            if (y[n] != exp_neg[n]) begin
                bad++; $display("FAIL neg_y%0d: got %0d want %0d", n, y[n], exp_neg[n]);
            end
        end
    endtask

    task automatic test_saturation();
        int v[16];
        int y[16];
        int lat[16];
        for (int i = 0; i < 16; i++) v[i] = 32767;
        load_block(v);
        collect(0, 16, y, lat);
        total++; if (y[0] != 32767) begin bad++; $display("FAIL sat_pos_y0: got %0d want 32767", y[0]); end
        for (int i = 0; i < 16; i++) v[i] = -32768;
        load_block(v);
        collect(0, 16, y, lat);
        total++; if (y[0] != -32768) begin bad++; $display("FAIL sat_neg_y0: got %0d want -32768", y[0]); end
    endtask

    task automatic test_backpressure();
        int v[16];
        int y[16];
        int lat[16];
        int wait_cnt;
        for (int i = 0; i < 16; i++) v[i] = 0;
        v[1] = 128;
        load_block(v);
        collect(0, 3, y, lat);
        out_ready = 1'b0;
        wait_cnt  = 0;
        while (out_valid !== 1'b1 && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        total++; if (wait_cnt != 16) begin bad++; $display("FAIL bp_lat_y3: got %0d want 16", wait_cnt); end
        total++;
        if (int'($signed(out_data)) != 85) begin
            bad++; $display("FAIL bp_y3: got %0d want 85", $signed(out_data));
        end
        // Inputs offered while stalled must be ignored.
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 16'h1234;
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c%0d: got %b want 1", c, out_valid); end
            total++;
            if (int'($signed(out_data)) != 85) begin
                bad++; $display("FAIL bp_data c%0d: got %0d want 85", c, $signed(out_data));
            end
            total++; if (rom_row !== 4'd0) begin bad++; $display("FAIL bp_rom_row c%0d: got %0d want 0", c, rom_row); end
            total++; if (rom_col !== 4'd0) begin bad++; $display("FAIL bp_rom_col c%0d: got %0d want 0", c, rom_col); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        collect(4, 16, y, lat);
        total++; if (lat[4] != 16) begin bad++; $display("FAIL bp_lat_y4: got %0d want 16", lat[4]); end
        for (int n = 4; n < 16; n++) begin
            total++;
            if (y[n] != exp_basis[n]) begin
                bad++; $display("FAIL bp_y%0d: got %0d want %0d", n, y[n], exp_basis[n]);
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        int v[16];
        int y[16];
        int lat[16];
        for (int i = 0; i < 16; i++) v[i] = 0;
        v[0] = 64;
        load_block(v);
        collect(0, 7, y, lat);
        repeat (5) @(negedge clk);
        total++; if (rom_row !== 4'd5) begin bad++; $display("FAIL mac_rom_row: got %0d want 5", rom_row); end
        total++; if (rom_col !== 4'd7) begin bad++; $display("FAIL mac_rom_col: got %0d want 7", rom_col); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mac_busy: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL macrst_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL macrst_busy: got %b want 0", busy); end
        total++; if (rom_row !== 4'd0) begin bad++; $display("FAIL macrst_rom_row: got %0d want 0", rom_row); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_block(v);
        collect(0, 16, y, lat);
        for (int n = 0; n < 16; n++) begin
            total++; if (y[n] != 32) begin bad++; $display("FAIL reload_y%0d: got %0d want 32", n, y[n]); end
            total++; if (lat[n] != 16) begin bad++; $display("FAIL reload_lat%0d: got %0d want 16", n, lat[n]); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rom_tab = '{
            '{64, 64, 64, 64, 64, 64, 64, 64, 64, 64, 64, 64, 64, 64, 64, 64},
            '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4},
            '{90, 87, 80, 70, 57, 43, 25, 9, -9, -25, -43, -57, -70, -80, -87, -90},
            '{90, 82, 67, 46, 22, -4, -31, -54, -73, -85, -90, -88, -78, -61, -38, -13},
            '{89, 75, 50, 18, -18, -50, -75, -89, -89, -75, -50, -18, 18, 50, 75, 89},
            '{88, 67, 31, -13, -54, -82, -90, -78, -46, -4, 38, 73, 90, 85, 61, 22},
            '{87, 57, 9, -43, -80, -90, -70, -25, 25, 70, 90, 80, 43, -9, -57, -87},
            '{85, 46, -13, -67, -90, -73, -22, 38, 82, 88, 54, -4, -61, -90, -78, -31},
            '{83, 36, -36, -83, -83, -36, 36, 83, 83, 36, -36, -83, -83, -36, 36, 83},
            '{82, 22, -54, -90, -61, 13, 78, 85, 31, -46, -90, -67, 4, 73, 88, 38},
            '{80, 9, -70, -87, -25, 57, 90, 43, -43, -90, -57, 25, 87, 70, -9, -80},
            '{78, -4, -82, -73, 13, 85, 67, -22, -88, -61, 31, 90, 54, -38, -90, -46},
            '{75, -18, -89, -50, 50, 89, 18, -75, -75, 18, 89, 50, -50, -89, -18, 75},
            '{73, -31, -90, -22, 78, 67, -38, -90, -13, 82, 61, -46, -88, -4, 85, 54},
            '{70, -43, -87, 9, 90, 25, -80, -57, 57, 80, -25, -90, -9, 87, 43, -70},
            '{67, -54, -78, 38, 85, -22, -90, 4, 90, 13, -88, -31, 82, 46, -73, -61}
        };
        test_reset();
        test_dc();
        test_basis_pause();
        test_reset_mid_load();
        test_saturation();
        test_backpressure();
        test_reset_mid_mac();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hevc_idct16_seq.md
HEVC_IDCT16_SEQ -- requirements
Module: hevc_idct16_seq

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning signed input sample width.
REQ-002 SHALL have parameter OUT_W, default 16, meaning signed output sample width.
REQ-003 SHALL have parameter SHIFT, default 7, meaning right shift applied after accumulation (SHIFT >= 1).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, meaning in_data holds a valid coefficient.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, IN_W, meaning signed transform coefficient X[k], k = 0..15 in arrival order.
REQ-009 SHALL have port rom_row, output, 4, meaning the row address to the 16x16 coefficient ROM (frequency index k).
REQ-010 SHALL have port rom_col, output, 4, meaning the column address to the ROM (sample index n).
REQ-011 SHALL have port rom_coeff, input, 8, meaning the signed ROM coefficient C[rom_row][rom_col], combinational in the same cycle.
REQ-012 SHALL have port out_valid, output, 1, meaning out_data holds a valid result.
REQ-013 SHALL have port out_ready, input, 1, meaning the consumer accepts out_data.
REQ-014 SHALL have port out_data, output, OUT_W, meaning signed result y[n], n = 0..15 in order.
REQ-015 SHALL have port busy, output, 1, meaning a block is partially loaded, computing or emitting.

Function
REQ-016 SHALL compute the 1-D inverse transform y[n] = sat(( sum over k=0..15 of X[k]*C[k][n] + 2^(SHIFT-1)) >>> SHIFT), arithmetic shift, saturated to the signed OUT_W range.
REQ-017 SHALL use a signed accumulator of IN_W+12 bits, so no intermediate overflow occurs.
REQ-018 SHALL implement FSM states LOAD, MAC and EMIT; reset state is LOAD.
REQ-019 LOAD: in_ready=1; each in_valid&&in_ready handshake stores in_data into buffer slot load_cnt and increments the 4-bit load_cnt; the handshake with load_cnt=15 wraps load_cnt to 0, sets n=0 and k=0, and moves to MAC.
REQ-020 MAC: in_ready=0, rom_row=k, rom_col=n; each cycle acc <= (k==0 ? 0 : acc) + buf[k]*rom_coeff, then k increments; after the k=15 update, the FSM moves to EMIT.
REQ-021 EMIT: out_valid=1 and out_data=sat(round(acc)); out_data and out_valid SHALL stay stable while out_ready=0.
REQ-022 EMIT with out_ready=1: if n=15, go to LOAD; otherwise n increments, k=0, and the FSM moves to MAC.
REQ-023 Outside MAC, rom_row and rom_col SHALL be 0.
REQ-024 Latency: out_valid for y[0] SHALL rise exactly 16 clock edges after the edge that accepts X[15]; each later y[n] SHALL follow 16 edges after the previous EMIT handshake.
REQ-025 Throughput with out_ready held at 1: one 16-sample block every 288 cycles (16 load + 16x17).
REQ-026 in_ready SHALL be 0 in MAC and EMIT; in_valid is ignored there and no sample is dropped or buffered.
REQ-027 busy SHALL be 1 when state != LOAD or load_cnt != 0.
REQ-028 in_valid deasserting mid-load SHALL pause loading with load_cnt held; no timeout.

Reset
REQ-029 rst=1 SHALL immediately force: state=LOAD, load_cnt=0, n=0, k=0, acc=0, out_valid=0, busy=0, rom_row=rom_col=0, and in_ready=1 after release; out_data=0.
REQ-030 Reset mid-load, mid-MAC or mid-EMIT SHALL discard the partial block; the next 16 accepted samples form a new block.

Verification
REQ-031 DC: X[0]=64, others 0 -> 16 outputs, each 32.
REQ-032 Basis: X[1]=128, others 0 -> outputs 90,90,88,85,82,78,73,67,61,54,46,38,31,22,13,4.
REQ-033 Negative rounding: X[2]=-128, others 0 -> outputs -90,-87,-80,-70,-57,-43,-25,-9,9,25,43,57,70,80,87,90.
REQ-034 Saturation: all X[k]=32767 -> y[0]=32767 (sum 32767*1291 exceeds range); no wrap to negative.
REQ-035 Backpressure: out_ready=0 for 5 cycles while y[3] is presented -> out_valid stays 1, out_data is unchanged, rom_row/col=0, in_ready=0; y[4] follows 16 edges after the handshake.
REQ-036 Reset during MAC of n=7 -> out_valid=0 and busy=0 immediately; reload of the DC vector yields 16 outputs of 32 with correct latency.
